// File: rtl/divisor_pkg.sv
// -----------------------------------------------------------------------------
// divisor_pkg
// Shared types and sizing for the sequential restoring divider. The control-unit
// bench imports this package as well.
//   estado_t   : divider FSM states (IDLE, ITER, DONE)
//   cnt_width  : iteration counter width for an n-bit divider
// -----------------------------------------------------------------------------
package divisor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } estado_t;

  localparam int unsigned N_DEF     = 8;
  localparam int unsigned CNT_W_DEF = $clog2(N_DEF) + 1;

  // Counter must hold n-1; one extra bit keeps it safe for any n >= 2.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/divisor_secuencial_restador_borrow.sv
// -----------------------------------------------------------------------------
// restador_borrow
// Combinational ripple-borrow subtractor: resta = A - B, borrow = 1 iff A < B.
//   A, B    in   n  operands (unsigned)
//   resta   out  n  difference modulo 2^n
//   borrow  out  1  borrow out of the MSB
// -----------------------------------------------------------------------------
module restador_borrow #(
  parameter int unsigned n = 9
) (
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] resta,
  output logic         borrow
);

  logic [n:0] w_b;

  // Bit-serial borrow chain, LSB first.
  always_comb begin
    w_b    = '0;
    resta  = '0;
    for (int i = 0; i < int'(n); i++) begin
      resta[i]  = A[i] ^ B[i] ^ w_b[i];
      w_b[i+1]  = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & w_b[i]);
    end
    borrow = w_b[n];
  end

endmodule

// File: rtl/divisor_secuencial.sv
// -----------------------------------------------------------------------------
// divisor_secuencial
// Unsigned restoring divider, one quotient bit per clock through a single shared
// (n+1)-bit subtractor. Results are held until the next accepted start.
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  request, only honoured while ready=1
//   dividendo  in   n  dividend, captured on accept
//   divisor    in   n  divisor, captured on accept
//   ready      out  1  idle, decoded from state
//   done       out  1  one-cycle pulse, results valid
//   cociente   out  n  quotient
//   residuo    out  n  remainder
//   div_cero   out  1  current result came from a zero divisor
// -----------------------------------------------------------------------------
module divisor_secuencial
  import divisor_pkg::*;
#(
  parameter int unsigned n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] dividendo,
  input  logic [n-1:0] divisor,
  output logic         ready,
  output logic         done,
  output logic [n-1:0] cociente,
  output logic [n-1:0] residuo,
  output logic         div_cero
);

  localparam int unsigned CW = cnt_width(n);

  estado_t       r_estado;
  estado_t       w_estado_sig;
  logic [CW-1:0] r_cnt;
  logic [n-1:0]  r_q;
  logic [n:0]    r_r;
  logic [n-1:0]  r_d;
  logic [n-1:0]  r_cociente;
  logic [n-1:0]  r_residuo;
  logic          r_div_cero;

  logic          w_accept;
  logic          w_div_zero;
  logic          w_last;
  logic [n:0]    w_s;
  logic [n:0]    w_t;
  logic          w_borrow;
  logic [n:0]    w_r_next;
  logic [n-1:0]  w_q_next;

  assign w_accept   = (r_estado == IDLE) && start;
  assign w_div_zero = (divisor == '0);
  assign w_last     = (r_cnt == '0);

  // Shift the next dividend bit into the partial remainder.
  assign w_s = {r_r[n-1:0], r_q[n-1]};

  restador_borrow #(
    .n (n + 1)
  ) u_restador (
    .A      (w_s),
    .B      ({1'b0, r_d}),
    .resta  (w_t),
    .borrow (w_borrow)
  );

  // Restore on borrow; quotient bit is the inverted borrow.
  assign w_r_next = w_borrow ? w_s : w_t;
  assign w_q_next = {r_q[n-2:0], ~w_borrow};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= IDLE;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  // Next state and state-decoded handshake.
  always_comb begin
    w_estado_sig = r_estado;
    ready        = 1'b0;
    done         = 1'b0;
    case (r_estado)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_estado_sig = w_div_zero ? DONE : ITER;
        end
      end
      ITER: begin
        if (w_last) begin
          w_estado_sig = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_estado_sig = IDLE;
      end
      default: begin
        w_estado_sig = IDLE;
      end
    endcase
  end

  // Working registers: operands, partial remainder/quotient and iteration count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_d   <= '0;
    end else if (w_accept) begin
      r_cnt <= CW'(n - 1);
      r_q   <= dividendo;
      r_r   <= '0;
      r_d   <= divisor;
    end else if (r_estado == ITER) begin
      r_q <= w_q_next;
      r_r <= w_r_next;
      if (!w_last) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // Result registers: loaded with the final iteration's values as DONE is
  // entered, or directly on accept for a zero divisor; otherwise held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cociente <= '0;
      r_residuo  <= '0;
      r_div_cero <= 1'b0;
    end else if (w_accept) begin
      r_div_cero <= w_div_zero;
      if (w_div_zero) begin
        r_cociente <= '1;
        r_residuo  <= dividendo;
      end
    end else if ((r_estado == ITER) && w_last) begin
      r_cociente <= w_q_next;
      r_residuo  <= w_r_next[n-1:0];
    end
  end

  assign cociente = r_cociente;
  assign residuo  = r_residuo;
  assign div_cero = r_div_cero;

  // Partial remainder never exceeds the divisor, so its top bit stays clear.
  a_r_msb_clear : assert property (@(posedge clk) disable iff (!rst_n) r_r[n] == 1'b0);

endmodule
